// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port, with a one-cycle bulk clear.
// Optional build macro REGARB_R0_ZERO_EN makes register 0 a hardwired zero.
module regfile_write_arbiter #(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [3:0]        req,
  input  logic [4*AW-1:0]   req_addr,
  input  logic [4*DW-1:0]   req_data,
  input  logic              clear_req,
  output logic [3:0]        req_ack,
  output logic [NREGS-1:0]  reg_en,
  output logic [DW-1:0]     reg_data,
  output logic [NREGS-1:0]  reg_clr,
  output logic [1:0]        grant_id,
  output logic              addr_err,
  output logic              busy
);

`ifdef REGARB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [AW:0]      NREGS_W  = (AW+1)'(NREGS);
  localparam logic [NREGS-1:0] CLR_IDLE = NREGS'(R0_ZERO);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [3:0]       eligible;
  logic             win_valid;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic             addr_ok;
  logic [NREGS-1:0] en_vec;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    eligible  = req & ~req_ack;
    win_valid = 1'b0;
    win       = ptr;
    idx       = ptr;
    // Scan from the farthest offset down so the nearest eligible index after ptr wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (eligible[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
    win_addr = req_addr[win*AW +: AW];
    win_data = req_data[win*DW +: DW];
    addr_ok  = {1'b0, win_addr} < NREGS_W;
    en_vec   = '0;
    for (int r = 0; r < NREGS; r++) begin
      en_vec[r] = addr_ok && (win_addr == AW'(r)) && !(R0_ZERO && r == 0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      req_ack  <= 4'b0;
      reg_en   <= '0;
      reg_data <= '0;
      reg_clr  <= '0;
      grant_id <= 2'd0;
      addr_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      req_ack  <= 4'b0;
      reg_en   <= '0;
      addr_err <= 1'b0;
      reg_clr  <= CLR_IDLE;
      // Leaving CLEAR always passes through IDLE, so a held clear_req cannot starve writers.
      if (state == IDLE && clear_req) begin
        state   <= CLEAR;
        reg_clr <= '1;
        busy    <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= |req;
        if (win_valid) begin
          req_ack  <= 4'b1 << win;
          reg_en   <= en_vec;
          reg_data <= win_data;
          grant_id <= win;
          addr_err <= ~addr_ok;
          ptr      <= win + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DW    = 16;
  localparam int NREGS = 12;
  localparam int AW    = 4;

`ifdef REGARB_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr_n;
  logic [3:0]       req;
  logic [4*AW-1:0]  req_addr;
  logic [4*DW-1:0]  req_data;
  logic             clear_req;
  logic [3:0]       req_ack;
  logic [NREGS-1:0] reg_en;
  logic [DW-1:0]    reg_data;
  logic [NREGS-1:0] reg_clr;
  logic [1:0]       grant_id;
  logic             addr_err;
  logic             busy;

  regfile_write_arbiter #(.DW(DW), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .clear_req(clear_req), .req_ack(req_ack), .reg_en(reg_en), .reg_data(reg_data),
    .reg_clr(reg_clr), .grant_id(grant_id), .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-requester address and data, packed onto the flat buses before each edge.
  logic [AW-1:0] a [4];
  logic [DW-1:0] d [4];

  // Model state: what the arbiter should present after the next edge.
  int               m_ptr;
  bit               m_clear;
  logic [3:0]       m_ack;
  logic [DW-1:0]    m_data;
  logic [1:0]       m_gid;
  logic [NREGS-1:0] m_en;
  logic [NREGS-1:0] m_clr;
  logic             m_err;
  logic             m_busy;

  task automatic model_reset();
    m_ptr = 0; m_clear = 0; m_ack = 0; m_data = 0; m_gid = 0;
    m_en = 0; m_clr = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    int w;
    logic [3:0] new_ack;
    m_en  = 0;
    m_err = 0;
    if (!m_clear && clear_req) begin
      m_clear = 1;
      m_ack   = 0;
      m_clr   = '1;
      m_busy  = 1;
    end else begin
      m_clear = 0;
      m_clr   = R0 ? NREGS'(1) : '0;
      m_busy  = |req;
      w = -1;
      for (int k = 0; k < 4; k++) begin
        int i = (m_ptr + k) % 4;
        if (w < 0 && req[i] && !m_ack[i]) w = i;
      end
      new_ack = 0;
      if (w >= 0) begin
        new_ack[w] = 1'b1;
        m_gid  = 2'(w);
        m_data = d[w];
        if (int'(a[w]) >= NREGS) m_err = 1;
        else if (!(R0 && a[w] == 0)) m_en = NREGS'(1) << a[w];
        m_ptr = (w + 1) % 4;
      end
      m_ack = new_ack;
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".ack"},  32'(req_ack),  32'(m_ack));
    check({pfx, ".en"},   32'(reg_en),   32'(m_en));
    check({pfx, ".data"}, 32'(reg_data), 32'(m_data));
    check({pfx, ".clr"},  32'(reg_clr),  32'(m_clr));
    check({pfx, ".gid"},  32'(grant_id), 32'(m_gid));
    check({pfx, ".err"},  32'(addr_err), 32'(m_err));
    check({pfx, ".busy"}, 32'(busy),     32'(m_busy));
  endtask

  // Called at a negedge with inputs set; returns at the following negedge with outputs checked.
  task automatic cycle(input string pfx);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(pfx);
  endtask

  initial begin
    clr_n = 1'b0; req = 0; clear_req = 0; req_addr = 0; req_data = 0;
    for (int i = 0; i < 4; i++) begin a[i] = 0; d[i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    clr_n = 1'b1;

    // Single write
    req = 4'b0001; a[0] = 4'd3; d[0] = 16'hBEEF;
    cycle("single");
    check("single.ack1",  32'(req_ack),  32'h1);
    check("single.en1",   32'(reg_en),   32'h008);
    check("single.data1", 32'(reg_data), 32'hBEEF);
    check("single.gid1",  32'(grant_id), 32'h0);
    cycle("single_hold");
    check("single.noreack", 32'(req_ack), 32'h0);
    req = 0;
    cycle("idle");

    // Clear collides with a request: clear first, then the write
    req = 4'b0100; a[2] = 4'd5; d[2] = 16'h5A5A; clear_req = 1'b1;
    cycle("coll_clr");
    check("coll.clr", 32'(reg_clr), 32'hFFF);
    check("coll.ack0", 32'(req_ack), 32'h0);
    clear_req = 1'b0;
    cycle("coll_wr");
    check("coll.ack", 32'(req_ack), 32'h4);
    req = 0;
    cycle("idle2");

    // Out-of-range address
    req = 4'b0010; a[1] = 4'd13; d[1] = 16'h0BAD;
    cycle("badaddr");
    check("bad.ack", 32'(req_ack), 32'h2);
    check("bad.en",  32'(reg_en),  32'h0);
    check("bad.err", 32'(addr_err), 32'h1);
    req = 0;
    cycle("badaddr_after");
    check("bad.err_pulse", 32'(addr_err), 32'h0);

    // Async reset during the ack cycle, then all four requesters held
    req = 4'b0001; a[0] = 4'd7; d[0] = 16'hCAFE;
    cycle("pre_rst");
    check("prerst.ack", 32'(req_ack), 32'h1);
    #2 clr_n = 1'b0;
    #1;
    check("arst.ack",  32'(req_ack),  32'h0);
    check("arst.en",   32'(reg_en),   32'h0);
    check("arst.data", 32'(reg_data), 32'h0);
    check("arst.gid",  32'(grant_id), 32'h0);
    check("arst.busy", 32'(busy),     32'h0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin a[i] = AW'(i + 1); d[i] = DW'(16'h1000 * (i + 1)); end
    for (int k = 0; k < 5; k++) begin
      cycle("rr");
      check("rr.gid",  32'(grant_id), 32'(k % 4));
      check("rr.onehot", 32'($countones(req_ack)), 32'd1);
    end

    // Held clear_req: CLEAR, one serving IDLE cycle, CLEAR again
    req = 4'b1000; clear_req = 1'b1;
    cycle("hold_c1");
    check("hold.clr1", 32'(reg_clr), 32'hFFF);
    cycle("hold_i");
    check("hold.ack", 32'(req_ack), 32'h8);
    cycle("hold_c2");
    check("hold.clr2", 32'(reg_clr), 32'hFFF);
    clear_req = 1'b0; req = 0;
    cycle("idle3");

`ifdef REGARB_R0_ZERO_EN
    req = 4'b0001; a[0] = 4'd0; d[0] = 16'h1234;
    cycle("r0");
    check("r0.ack", 32'(req_ack), 32'h1);
    check("r0.en",  32'(reg_en),  32'h0);
    check("r0.clr0", 32'(reg_clr[0]), 32'h1);
    check("r0.err", 32'(addr_err), 32'h0);
    req = 0;
    cycle("r0_after");
`endif

    // Randomized traffic obeying the hold-until-ack protocol, with occasional withdrawals
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          a[i] = AW'($urandom_range(0, 15));
          d[i] = DW'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 15));
          d[i] = DW'($urandom);
        end
      end
      if (clear_req) clear_req = ($urandom_range(0, 1) == 0);
      else           clear_req = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
